// File: rtl/i2s_slave_rx.sv
`default_nettype none
// ============================================================================
// Module      : i2s_slave_rx
// Description : I2S slave receiver. Oversamples the external bit clock, word
//               select and data in the clk domain, recovers left/right words
//               (MSB first, one-bit I2S delay after each word-select change)
//               and presents complete stereo frames on an AXI-Stream style
//               valid/ready output.
// Ports       : clk, rst          - system clock, synchronous active-high reset
//               sclk, lrck, sdi   - asynchronous I2S bit clock, word select, data
//               m_axis_data_lc/rc - left/right sample of the presented frame
//               m_axis_valid/ready- output handshake
//               locked            - framing aligned (left slot seen)
//               overflow          - pulse: completed frame dropped (backpressure)
//               frame_err         - pulse: slot ended before a full word
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_slave_rx #(
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  lrck,
    input  logic                  sdi,
    output logic [DATA_WIDTH-1:0] m_axis_data_lc,
    output logic [DATA_WIDTH-1:0] m_axis_data_rc,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic                  locked,
    output logic                  overflow,
    output logic                  frame_err
);

    localparam int              CW         = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0]   C_CNT_FULL = CW'(DATA_WIDTH);
    localparam logic [CW-1:0]   C_CNT_LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        SYNC_WAIT = 2'd0,
        RX_LEFT   = 2'd1,
        RX_RIGHT  = 2'd2
    } state_t;

    // Synchronizers (sclk has one extra stage for edge detection)
    logic sclk_meta_q, sclk_sync_q, sclk_dly_q;
    logic lrck_meta_q, lrck_sync_q;
    logic sdi_meta_q,  sdi_sync_q;

    // Receive datapath
    state_t                state_q;
    logic                  lrck_prev_q;
    logic [CW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] left_hold_q;
    logic                  left_ok_q;

    // Completed-frame pipeline stage feeding the output register
    logic                  frame_q;
    logic [DATA_WIDTH-1:0] frame_lc_q;
    logic [DATA_WIDTH-1:0] frame_rc_q;

    logic                  sclk_rise;
    logic                  lr_chg;
    logic [DATA_WIDTH-1:0] shift_d;

    always_comb begin
        sclk_rise = sclk_sync_q & ~sclk_dly_q;
        lr_chg    = sclk_rise & (lrck_sync_q != lrck_prev_q);
        shift_d   = {shift_q[DATA_WIDTH-2:0], sdi_sync_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_dly_q  <= 1'b0;
            lrck_meta_q <= 1'b0;
            lrck_sync_q <= 1'b0;
            sdi_meta_q  <= 1'b0;
            sdi_sync_q  <= 1'b0;
            state_q     <= SYNC_WAIT;
            lrck_prev_q <= 1'b0;
            cnt_q       <= '0;
            shift_q     <= '0;
            left_hold_q <= '0;
            left_ok_q   <= 1'b0;
            frame_q     <= 1'b0;
            frame_lc_q  <= '0;
            frame_rc_q  <= '0;
            locked      <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            sclk_meta_q <= sclk;
            sclk_sync_q <= sclk_meta_q;
            sclk_dly_q  <= sclk_sync_q;
            lrck_meta_q <= lrck;
            lrck_sync_q <= lrck_meta_q;
            sdi_meta_q  <= sdi;
            sdi_sync_q  <= sdi_meta_q;

            frame_q   <= 1'b0;
            frame_err <= 1'b0;

            if (sclk_rise) begin
                lrck_prev_q <= lrck_sync_q;
            end

            if (lr_chg) begin
                // sdi on this rise is the previous word's trailing LSB slot
                cnt_q   <= '0;
                shift_q <= '0;
                if (state_q != SYNC_WAIT && cnt_q < C_CNT_FULL) begin
                    frame_err <= 1'b1;
                    left_ok_q <= 1'b0;
                end
                case (state_q)
                    SYNC_WAIT: if (!lrck_sync_q) begin
                        state_q <= RX_LEFT;
                        locked  <= 1'b1;
                    end
                    RX_LEFT:   if (lrck_sync_q)  state_q <= RX_RIGHT;
                    RX_RIGHT:  if (!lrck_sync_q) state_q <= RX_LEFT;
                    default:   state_q <= SYNC_WAIT;
                endcase
            end else if (sclk_rise && cnt_q < C_CNT_FULL) begin
                // Bits past DATA_WIDTH are slot padding; counter saturates
                shift_q <= shift_d;
                cnt_q   <= cnt_q + CW'(1);
                if (cnt_q == C_CNT_LAST) begin
                    if (state_q == RX_LEFT) begin
                        left_hold_q <= shift_d;
                        left_ok_q   <= 1'b1;
                    end else if (state_q == RX_RIGHT && left_ok_q) begin
                        frame_q    <= 1'b1;
                        frame_lc_q <= left_hold_q;
                        frame_rc_q <= shift_d;
                        left_ok_q  <= 1'b0;
                    end
                end
            end
        end
    end

    // Output register: a new frame may replace the held one only when the
    // held one is absent or being consumed in this same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_data_lc <= '0;
            m_axis_data_rc <= '0;
            m_axis_valid   <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (frame_q) begin
                if (!m_axis_valid || m_axis_ready) begin
                    m_axis_data_lc <= frame_lc_q;
                    m_axis_data_rc <= frame_rc_q;
                    m_axis_valid   <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (m_axis_valid && m_axis_ready) begin
                m_axis_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/i2s_slave_rx.md
I2S_SLAVE_RX -- requirements
Module: i2s_slave_rx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 24, meaning audio sample width in bits (range 8..32).
REQ-002 The block SHALL have port clk, input, 1 bit: system clock; all logic is in this single domain.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port sclk, input, 1 bit: external I2S bit clock, asynchronous to clk; clk SHALL be at least 8x sclk.
REQ-005 The block SHALL have port lrck, input, 1 bit: external word select; 0 = left, 1 = right.
REQ-006 The block SHALL have port sdi, input, 1 bit: external serial data, MSB first.
REQ-007 The block SHALL have port m_axis_data_lc, output, DATA_WIDTH bits: left sample, two's complement.
REQ-008 The block SHALL have port m_axis_data_rc, output, DATA_WIDTH bits: right sample, two's complement.
REQ-009 The block SHALL have port m_axis_valid, output, 1 bit: stereo frame available.
REQ-010 The block SHALL have port m_axis_ready, input, 1 bit: downstream accepts the frame.
REQ-011 The block SHALL have port locked, output, 1 bit: high once framing is aligned.
REQ-012 The block SHALL have port overflow, output, 1 bit: one-cycle pulse when a completed frame is dropped.
REQ-013 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when a slot is short.

Function
REQ-014 The block SHALL pass sclk, lrck and sdi through identical 2-FF synchronizers and SHALL detect an sclk rise when the synchronized value is 1 and its one-cycle-delayed copy is 0.
REQ-015 On each detected sclk rise, the block SHALL sample synchronized lrck and sdi together; no action SHALL occur on other cycles.
REQ-016 An lrck-change rise is a rise where sampled lrck differs from the value sampled at the previous rise; sdi at that rise SHALL be ignored, because it is the LSB slot of the prior word.
REQ-017 On an lrck-change rise, the block SHALL clear the bit counter and shift register; on the next DATA_WIDTH rises, it SHALL shift sdi in MSB first.
REQ-018 Rises after the first DATA_WIDTH in a slot (32-bit slot padding) SHALL be ignored; the bit counter SHALL saturate at DATA_WIDTH.
REQ-019 The block SHALL use an FSM with states SYNC_WAIT, RX_LEFT and RX_RIGHT; reset SHALL enter SYNC_WAIT.
REQ-020 SYNC_WAIT SHALL go to RX_LEFT on the first lrck 1->0 change rise.
REQ-021 RX_LEFT SHALL go to RX_RIGHT on a 0->1 change rise, and RX_RIGHT SHALL go to RX_LEFT on a 1->0 change rise.
REQ-022 locked SHALL be high in RX_LEFT and RX_RIGHT.
REQ-023 A left word completing in RX_LEFT SHALL be latched into a left holding register, setting left_ok.
REQ-024 A right word completing in RX_RIGHT with left_ok=1 SHALL form a frame and clear left_ok.
REQ-025 A right word completing in RX_RIGHT with left_ok=0 SHALL be discarded.
REQ-026 If an lrck change occurs with the bit counter below DATA_WIDTH in RX_LEFT or RX_RIGHT, the block SHALL pulse frame_err, discard the partial word, clear left_ok, and take the normal FSM transition.
REQ-027 Output stage: on frame completion with m_axis_valid=0, or with m_axis_valid=1 and m_axis_ready=1 in the same cycle, the block SHALL load data and hold m_axis_valid=1 with no overflow.
REQ-028 On frame completion with m_axis_valid=1 and m_axis_ready=0, the block SHALL keep the old frame and pulse overflow.
REQ-029 m_axis_valid SHALL deassert on the handshake when no new frame completes; data SHALL be stable while m_axis_valid=1 and m_axis_ready=0.
REQ-030 Latency: if clk edge k first samples the sclk rise carrying the last right data bit, m_axis_valid SHALL be high after edge k+3.
REQ-031 Output registers SHALL be the only drivers of m_axis_* signals; there SHALL be no combinational path from m_axis_ready to m_axis_valid.

Reset
REQ-032 On rst=1 at a clk edge, the block SHALL clear all synchronizers, shift and holding registers, bit counter, left_ok, m_axis_data_lc, m_axis_data_rc, m_axis_valid, locked, overflow and frame_err to 0, and set the FSM to SYNC_WAIT.
REQ-033 Reset mid-slot or while m_axis_valid=1 SHALL drop the pending frame; no handshake SHALL be required.
REQ-034 After reset release, the first frame SHALL be emitted only after a full left slot and a full right slot.

Verification
REQ-035 Nominal: clk 100 MHz, sclk 3.072 MHz, 64 sclk/frame, left 0x123456, right 0xABCDEF, ready=1 -> one valid beat per frame with lc=0x123456, rc=0xABCDEF; valid high 4 clk edges after the last right bit rise (edge k+3).
REQ-036 Lock: release reset mid right slot -> locked=0 until the first lrck 1->0 change; no valid until the following right slot completes; frame_err=0.
REQ-037 Backpressure: ready=0 for 3 frames (A, B, C), then 1 -> data=A held stable; overflow pulses exactly twice (for B and C); A is delivered, then the next frame D.
REQ-038 Simultaneous: ready rises in the same cycle a new frame completes -> old frame consumed, new frame loaded, valid stays 1, overflow=0.
REQ-039 Short slot: lrck toggles after 10 bits in a left slot -> one frame_err pulse; that frame not emitted; the next full frame emitted correctly.
REQ-040 Sign and MSB: left 0x800000, right 0x000001 with DATA_WIDTH=24 -> lc=0x800000, rc=0x000001 exactly.
